piso_serializer: RTL and testbench

- Downstream stage of the 4-bit parallel-in/parallel-out register.
- Accepts the register's 4-bit word on a ready/valid load handshake and shifts it out one bit per clock on a single serial line.
- Provides sout_valid and last framing for the serial consumer, a hold input for stalls, and back-to-back word streaming with no idle gap.

---
 rtl/piso_serializer.sv | 111 +++++++++++
 tb/tb_piso_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: takes a 4-bit word {pa,pb,pc,pd} on a ready/valid load
// handshake and shifts it out one bit per clock with valid/last framing.
// Supports hold stalls and back-to-back words with no idle gap.
module piso_serializer #(
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pa,
   input  logic pb,
   input  logic pc,
   input  logic pd,
   input  logic load_valid,
   output logic load_ready,
   input  logic hold,
   output logic sout,
   output logic sout_valid,
   output logic last
);

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 2;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  sr_q, sr_d;
   logic          sout_q, sout_d;
   logic          sout_valid_q, sout_valid_d;
   logic          last_q, last_d;

   logic [W-1:0]  word_c;
   logic          accept_c;

   // Ready in IDLE, or on the final bit of a word when not stalled
   always_comb begin
      load_ready = (state_q == S_IDLE) ||
                   ((state_q == S_SHIFT) && (cnt_q == CNT_LAST) && !hold);
   end

   // Incoming word arranged so that bit W-1 is always transmitted first
   always_comb begin
      word_c   = MSB_FIRST ? {pa, pb, pc, pd} : {pd, pc, pb, pa};
      accept_c = load_valid && load_ready;
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      sout_d       = sout_q;
      sout_valid_d = sout_valid_q;
      last_d       = last_q;

      if (accept_c) begin
         // Fresh load from IDLE, or back-to-back reload on the last bit
         state_d      = S_SHIFT;
         cnt_d        = '0;
         sout_d       = word_c[W-1];
         sr_d         = {word_c[W-2:0], 1'b0};
         sout_valid_d = 1'b1;
         last_d       = 1'b0;
      end else if ((state_q == S_SHIFT) && !hold) begin
         if (cnt_q != CNT_LAST) begin
            cnt_d  = cnt_q + CW'(1);
            sout_d = sr_q[W-1];
            sr_d   = {sr_q[W-2:0], 1'b0};
            last_d = ((cnt_q + CW'(1)) == CNT_LAST);
         end else begin
            // Word finished with nothing queued: drop back to idle line
            state_d      = S_IDLE;
            cnt_d        = '0;
            sr_d         = '0;
            sout_d       = IDLE_LEVEL;
            sout_valid_d = 1'b0;
            last_d       = 1'b0;
         end
      end
   end

   // State and output registers; reset discards any word in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         sr_q         <= '0;
         sout_q       <= IDLE_LEVEL;
         sout_valid_q <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         last_q       <= last_d;
      end
   end

   assign sout       = sout_q;
   assign sout_valid = sout_valid_q;
   assign last       = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first instance (idle level 0) and an
// LSB-first instance (idle level 1) share stimulus and are checked against
// a word/bit-position reference model.
module tb_piso_serializer;

   logic clk = 1'b0;
   logic rst;
   logic pa, pb, pc, pd;
   logic load_valid;
   logic hold;

   logic lr0, so0, sv0, la0;
   logic lr1, so1, sv1, la1;

   int errors = 0;
   int checks = 0;

   // Reference model: current word and which of its bits (1..4) is on the
   // line; 0 means nothing is being transmitted.
   logic [3:0] mw = 4'b0000;
   int         mk = 0;

   // Bits seen while sout_valid was high, for whole-sequence checks
   logic [7:0] cap0, cap1;
   int         ncap;

   piso_serializer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
      .clk(clk), .rst(rst),
      .pa(pa), .pb(pb), .pc(pc), .pd(pd),
      .load_valid(load_valid), .load_ready(lr0), .hold(hold),
      .sout(so0), .sout_valid(sv0), .last(la0)
   );

   piso_serializer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
      .clk(clk), .rst(rst),
      .pa(pa), .pb(pb), .pc(pc), .pd(pd),
      .load_valid(load_valid), .load_ready(lr1), .hold(hold),
      .sout(so1), .sout_valid(sv1), .last(la1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic set_in(input logic v, input logic [3:0] w, input logic h);
      {pa, pb, pc, pd} = w;
      load_valid = v;
      hold       = h;
   endtask

   task automatic clear_cap();
      cap0 = '0;
      cap1 = '0;
      ncap = 0;
   endtask

   // Compare registered outputs of both instances with the model
   task automatic check_out(input string tag);
      logic e_v, e_l, e_s0, e_s1;
      if (mk == 0) begin
         e_v = 1'b0; e_l = 1'b0; e_s0 = 1'b0; e_s1 = 1'b1;
      end else begin
         e_v  = 1'b1;
         e_l  = (mk == 4);
         e_s0 = mw[4 - mk];   // pa first
         e_s1 = mw[mk - 1];   // pd first
      end
      chk({tag, ":sout_msb"},  8'(so0), 8'(e_s0));
      chk({tag, ":valid_msb"}, 8'(sv0), 8'(e_v));
      chk({tag, ":last_msb"},  8'(la0), 8'(e_l));
      chk({tag, ":sout_lsb"},  8'(so1), 8'(e_s1));
      chk({tag, ":valid_lsb"}, 8'(sv1), 8'(e_v));
      chk({tag, ":last_lsb"},  8'(la1), 8'(e_l));
   endtask

   // One clock: check load_ready pre-edge, advance model, check outputs post-edge
   task automatic step(input string tag);
      logic rdy;
      #1;
      rdy = (mk == 0) || ((mk == 4) && !hold);
      chk({tag, ":ready_msb"}, 8'(lr0), 8'(rdy));
      chk({tag, ":ready_lsb"}, 8'(lr1), 8'(rdy));
      if (!rst) begin
         mk = 0;
      end else if ((mk != 0) && hold) begin
         mk = mk;
      end else if (rdy && load_valid) begin
         mw = {pa, pb, pc, pd};
         mk = 1;
      end else if ((mk >= 1) && (mk <= 3)) begin
         mk = mk + 1;
      end else begin
         mk = 0;
      end
      @(posedge clk);
      #1;
      check_out(tag);
      if (sv0 === 1'b1) begin
         cap0 = {cap0[6:0], so0};
         cap1 = {cap1[6:0], so1};
         ncap++;
      end
   endtask

   initial begin
      rst = 1'b0;
      set_in(1'b0, 4'b0000, 1'b0);
      clear_cap();

      // Reset held low, then released with no load
      step("rst_low");
      step("rst_low");
      rst = 1'b1;
      repeat (2) step("idle");

      // Single word 1011: MSB-first 1,0,1,1; LSB-first 1,1,0,1
      clear_cap();
      set_in(1'b1, 4'b1011, 1'b0);
      step("w1011_acc");
      set_in(1'b0, 4'b0000, 1'b0);
      repeat (5) step("w1011");
      chk("w1011_seq_msb", cap0, 8'b0000_1011);
      chk("w1011_seq_lsb", cap1, 8'b0000_1101);
      chk("w1011_nbits", 8'(ncap), 8'd4);

      // Word 0001: LSB-first gives 1,0,0,0
      clear_cap();
      set_in(1'b1, 4'b0001, 1'b0);
      step("w0001_acc");
      set_in(1'b0, 4'b0000, 1'b0);
      repeat (5) step("w0001");
      chk("w0001_seq_lsb", cap1, 8'b0000_1000);
      chk("w0001_seq_msb", cap0, 8'b0000_0001);

      // Back-to-back 0101 then 1111 with load_valid held high
      clear_cap();
      set_in(1'b1, 4'b0101, 1'b0);
      step("b2b_acc1");
      set_in(1'b1, 4'b1111, 1'b0);
      repeat (4) step("b2b_w1");
      set_in(1'b0, 4'b0000, 1'b0);
      repeat (5) step("b2b_w2");
      chk("b2b_seq_msb", cap0, 8'b0101_1111);
      chk("b2b_nbits", 8'(ncap), 8'd8);

      // Hold for 3 cycles while the 2nd bit of 0110 is out
      clear_cap();
      set_in(1'b1, 4'b0110, 1'b0);
      step("hold_acc");
      set_in(1'b0, 4'b0000, 1'b0);
      step("hold_bit2");
      set_in(1'b0, 4'b0000, 1'b1);
      repeat (3) step("hold_on");
      set_in(1'b0, 4'b0000, 1'b0);
      repeat (4) step("hold_off");
      chk("hold_seq_msb", cap0, 8'b0011_1110);
      chk("hold_nbits", 8'(ncap), 8'd7);

      // Hold on the last bit blocks a pending reload
      set_in(1'b1, 4'b1010, 1'b0);
      step("hl_acc");
      set_in(1'b0, 4'b0000, 1'b0);
      repeat (3) step("hl_shift");
      set_in(1'b1, 4'b0011, 1'b1);
      repeat (2) step("hl_blocked");
      chk("hl_ready_blocked", 8'(lr0), 8'd0);
      set_in(1'b1, 4'b0011, 1'b0);
      step("hl_reload");
      set_in(1'b0, 4'b0000, 1'b0);
      repeat (5) step("hl_drain");

      // Inputs wiggle after accepting 1001
      clear_cap();
      set_in(1'b1, 4'b1001, 1'b0);
      step("iso_acc");
      repeat (5) begin
         set_in(1'b0, 4'($urandom), 1'b0);
         step("iso");
      end
      chk("iso_seq_msb", cap0, 8'b0000_1001);

      // Asynchronous reset mid-word
      set_in(1'b1, 4'b1111, 1'b0);
      step("ar_acc");
      set_in(1'b0, 4'b0000, 1'b0);
      step("ar_shift");
      #2 rst = 1'b0;
      #1;
      mk = 0;
      chk("ar_sout_msb",  8'(so0), 8'd0);
      chk("ar_valid_msb", 8'(sv0), 8'd0);
      chk("ar_last_msb",  8'(la0), 8'd0);
      chk("ar_ready_msb", 8'(lr0), 8'd1);
      chk("ar_sout_lsb",  8'(so1), 8'd1);
      chk("ar_valid_lsb", 8'(sv1), 8'd0);
      repeat (2) step("ar_low");
      rst = 1'b1;
      repeat (3) step("ar_release");

      // Randomized traffic
      repeat (300) begin
         set_in(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) == 0));
         step("rand");
      end
      set_in(1'b0, 4'b0000, 1'b0);
      repeat (6) step("rand_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
